// File: rtl/exe_div_unit.sv
// rtl/exe_div_unit.sv - iterative radix-2 restoring DIV/DIVU unit for the EXE stage
// Optional early-out for |dividend| < |divisor| when DIV_EARLY_OUT_EN is defined.
module exe_div_unit #(
  parameter int          DATA_W     = 32,
  parameter int          CNT_W      = 6,
  parameter logic [7:0]  ALUOP_DIV  = 8'h16,
  parameter logic [7:0]  ALUOP_DIVU = 8'h17
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              flush,
  input  logic              exe_hold,
  input  logic [7:0]        exe_aluop,
  input  logic [DATA_W-1:0] exe_src1,
  input  logic [DATA_W-1:0] exe_src2,
  output logic              stallreq_div,
  output logic              div_ready,
  output logic [DATA_W-1:0] div_hi,
  output logic [DATA_W-1:0] div_lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem, quo, divisor;
  logic              sign_q, sign_r;

  logic              is_div, div_op, s1, s2, fits, early_out;
  logic [DATA_W-1:0] mag1, mag2, rem_nx, quo_nx;
  logic [DATA_W:0]   rem_sh;

  assign is_div = (exe_aluop == ALUOP_DIV);
  assign div_op = is_div || (exe_aluop == ALUOP_DIVU);
  assign s1     = is_div & exe_src1[DATA_W-1];
  assign s2     = is_div & exe_src2[DATA_W-1];
  assign mag1   = s1 ? -exe_src1 : exe_src1;
  assign mag2   = s2 ? -exe_src2 : exe_src2;

  // Partial remainder needs one extra bit after the shift; the difference always fits DATA_W.
  assign rem_sh = {rem, quo[DATA_W-1]};
  assign fits   = rem_sh >= {1'b0, divisor};
  assign rem_nx = fits ? (rem_sh[DATA_W-1:0] - divisor) : rem_sh[DATA_W-1:0];
  assign quo_nx = {quo[DATA_W-2:0], fits};

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (mag1 < mag2);
`else
  assign early_out = 1'b0;
`endif

  assign stallreq_div = div_op && (state != S_DONE);

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      divisor   <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      div_ready <= 1'b0;
      div_hi    <= '0;
      div_lo    <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      cnt       <= '0;
      div_ready <= 1'b0;
      div_hi    <= '0;
      div_lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (div_op) begin
            if (mag2 == '0) begin
              state     <= S_DONE;
              div_lo    <= '1;
              div_hi    <= exe_src1;
              div_ready <= 1'b1;
            end else if (early_out) begin
              state     <= S_DONE;
              div_lo    <= '0;
              div_hi    <= exe_src1;
              div_ready <= 1'b1;
            end else begin
              state   <= S_CALC;
              cnt     <= '0;
              rem     <= '0;
              quo     <= mag1;
              divisor <= mag2;
              sign_q  <= s1 ^ s2;
              sign_r  <= s1;
            end
          end
        end
        S_CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            state     <= S_DONE;
            div_lo    <= sign_q ? -quo_nx : quo_nx;
            div_hi    <= sign_r ? -rem_nx : rem_nx;
            div_ready <= 1'b1;
          end
        end
        S_DONE: begin
          if (!exe_hold) begin
            state     <= S_IDLE;
            div_ready <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_div_unit.sv
// tb/tb_exe_div_unit.sv - scoreboard bench for exe_div_unit
module tb_exe_div_unit;

  localparam logic [7:0] OP_DIV  = 8'h16;
  localparam logic [7:0] OP_DIVU = 8'h17;
  localparam logic [7:0] OP_NOP  = 8'h00;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst_n, flush, exe_hold;
  logic [7:0]  exe_aluop;
  logic [31:0] exe_src1, exe_src2;
  logic        stallreq_div, div_ready;
  logic [31:0] div_hi, div_lo;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  exe_div_unit dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .flush       (flush),
    .exe_hold    (exe_hold),
    .exe_aluop   (exe_aluop),
    .exe_src1    (exe_src1),
    .exe_src2    (exe_src2),
    .stallreq_div(stallreq_div),
    .div_ready   (div_ready),
    .div_hi      (div_hi),
    .div_lo      (div_lo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [31:0] sa, sb;
    logic [31:0] ma, mb;
    sa = a;
    sb = b;
    ma = a;
    mb = b;
    if (b == 32'd0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = a;
    end else if (op == OP_DIVU) begin
      e.lo = a / b;
      e.hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000;
      e.hi = 32'd0;
    end else begin
      e.lo = sa / sb;
      e.hi = sa % sb;
    end
    if (op == OP_DIV) begin
      if (sa < 0) ma = 32'd0 - a;
      if (sb < 0) mb = 32'd0 - b;
    end
    e.lat = (b == 32'd0) ? 1 : 33;
`ifdef DIV_EARLY_OUT_EN
    if (b != 32'd0 && ma < mb) e.lat = 1;
`endif
    if (ma == mb) e.lat = e.lat;
    return e;
  endfunction

  // Called at a negedge in an IDLE cycle; returns at a negedge in the following IDLE cycle.
  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t e;
    int   lat, stalls;
    sb_q.push_back(model(op, a, b));
    exe_aluop = op;
    exe_src1  = a;
    exe_src2  = b;
    #1;
    lat    = 0;
    stalls = 0;
    while (!div_ready && lat < 100) begin
      if (stallreq_div) stalls++;
      @(negedge cpu_clk_50M);
      lat++;
      if (lat == 5) begin
        exe_src1 = $urandom;
        exe_src2 = $urandom;
      end
    end
    if (lat >= 100) chk("ready_timeout", 32'd0, 32'd1);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("latency", lat, e.lat);
      chk("stall_cycles", stalls, e.lat);
      chk("lo", div_lo, e.lo);
      chk("hi", div_hi, e.hi);
      chk("stall_in_done", {31'd0, stallreq_div}, 32'd0);
      for (int i = 0; i < hold; i++) begin
        exe_hold = 1'b1;
        @(negedge cpu_clk_50M);
        chk("hold_ready", {31'd0, div_ready}, 32'd1);
        chk("hold_lo", div_lo, e.lo);
        chk("hold_hi", div_hi, e.hi);
        chk("hold_stall", {31'd0, stallreq_div}, 32'd0);
      end
    end
    exe_hold  = 1'b0;
    exe_aluop = OP_NOP;
    @(negedge cpu_clk_50M);
    chk("ready_drop", {31'd0, div_ready}, 32'd0);
  endtask

  task automatic abort_div(input bit use_reset);
    exe_aluop = OP_DIVU;
    exe_src1  = 32'd1000;
    exe_src2  = 32'd3;
    repeat (10) @(negedge cpu_clk_50M);
    chk("abort_mid_stall", {31'd0, stallreq_div}, 32'd1);
    if (use_reset) cpu_rst_n = 1'b0;
    else           flush     = 1'b1;
    exe_aluop = OP_NOP;
    @(negedge cpu_clk_50M);
    chk("abort_ready", {31'd0, div_ready}, 32'd0);
    chk("abort_lo", div_lo, 32'd0);
    chk("abort_hi", div_hi, 32'd0);
    chk("abort_stall", {31'd0, stallreq_div}, 32'd0);
    flush     = 1'b0;
    cpu_rst_n = 1'b1;
    @(negedge cpu_clk_50M);
  endtask

  initial begin
    cpu_rst_n = 1'b0;
    flush     = 1'b0;
    exe_hold  = 1'b0;
    exe_aluop = OP_DIV;
    exe_src1  = 32'd77;
    exe_src2  = 32'd5;
    repeat (2) @(negedge cpu_clk_50M);
    chk("rst_ready", {31'd0, div_ready}, 32'd0);
    chk("rst_lo", div_lo, 32'd0);
    chk("rst_hi", div_hi, 32'd0);
    exe_aluop = OP_NOP;
    cpu_rst_n = 1'b1;
    @(negedge cpu_clk_50M);
    chk("idle_stall", {31'd0, stallreq_div}, 32'd0);
    chk("idle_ready", {31'd0, div_ready}, 32'd0);

    run_div(OP_DIVU, 32'd100, 32'd7, 3);
    run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    run_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(OP_DIV, 32'd5, 32'd0, 0);
    run_div(OP_DIVU, 32'hDEAD_BEEF, 32'd0, 1);
    run_div(OP_DIVU, 32'd3, 32'd10, 0);
    run_div(OP_DIV, 32'hFFFF_FFFD, 32'd10, 0);
    run_div(OP_DIVU, 32'd9, 32'd3, 0);
    run_div(OP_DIVU, 32'd8, 32'd3, 0);
    run_div(OP_DIV, 32'd100, 32'hFFFF_FFF9, 0);
    run_div(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 0);

    abort_div(1'b0);
    run_div(OP_DIVU, 32'd50, 32'd6, 0);
    run_div(OP_DIVU, 32'd1, 32'd1, 0);
    abort_div(1'b1);
    run_div(OP_DIV, 32'hFFFF_FF00, 32'hFFFF_FFF0, 0);

    for (int i = 0; i < 6; i++) begin
      run_div((i % 2 == 0) ? OP_DIV : OP_DIVU, $urandom, $urandom_range(1, 32'h0FFF_FFFF) ^ ((i > 2) ? 32'h8000_0000 : 32'd0), i % 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
